droute_sched: RTL



---
 rtl/droute_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/droute_sched.sv
// Configuration sequencer for data_route: loads a table of {switch_1, switch_0, beats}
// entries and, on start, applies each one once the route is quiescent and both count strobes are satisfied.
module droute_sched #(
  parameter int SW_W  = 18,
  parameter int CNT_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*SW_W+CNT_W-1:0]   s_cfg_tdata,
  input  logic                      s_cfg_tvalid,
  output logic                      s_cfg_tready,
  input  logic                      s_cfg_tlast,
  input  logic                      start,
  input  logic                      count_switch_0_tvalid,
  input  logic                      count_switch_1_tvalid,
  input  logic [4:0]                in_valid,
  output logic [SW_W-1:0]           s_droute_switch_0,
  output logic [SW_W-1:0]           s_droute_switch_1,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(DEPTH)-1:0]  cur_idx
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = 2*SW_W + CNT_W;

  typedef enum logic [1:0] {IDLE, QUIESCE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   tbl [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, n_entries;
  logic               sealed;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt0, cnt1, beats_q;
  logic [CNT_W-1:0]   cnt0_nx, cnt1_nx;
  logic [SW_W-1:0]    sw0_q, sw1_q;
  logic               busy_q, done_q, err_q;
  logic [ENT_W-1:0]   cur_ent;
  logic               cfg_hs, entry_done, last_entry;
  logic               start_ok, start_bad, load_entry, advance;

  assign s_cfg_tready = (state_q == IDLE) && (wr_ptr < PTR_W'(DEPTH));
  assign cfg_hs       = s_cfg_tvalid && s_cfg_tready;
  assign cur_ent      = tbl[idx];

  // Counters saturate at beats, so the completion test can look at this cycle's strobe directly.
  assign cnt0_nx    = (count_switch_0_tvalid && (cnt0 < beats_q)) ? cnt0 + CNT_W'(1) : cnt0;
  assign cnt1_nx    = (count_switch_1_tvalid && (cnt1 < beats_q)) ? cnt1 + CNT_W'(1) : cnt1;
  assign entry_done = (cnt0_nx >= beats_q) && (cnt1_nx >= beats_q);
  assign last_entry = ({1'b0, idx} == (n_entries - PTR_W'(1)));

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    load_entry = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: begin
        // A config write in the same cycle takes priority over start.
        if (start && !cfg_hs) begin
          if (sealed && (n_entries != '0)) begin
            start_ok = 1'b1;
            state_d  = QUIESCE;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      QUIESCE: begin
        if (in_valid == '0) begin
          load_entry = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (entry_done) begin
          if (last_entry) begin
            state_d = FINISH;
          end else begin
            advance = 1'b1;
            state_d = QUIESCE;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (cfg_hs) tbl[wr_ptr[IDX_W-1:0]] <= s_cfg_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      n_entries <= '0;
      sealed    <= 1'b0;
      idx       <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
      beats_q   <= '0;
      sw0_q     <= '0;
      sw1_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= start_bad;
      done_q <= (state_d == FINISH);

      if (cfg_hs) begin
        if (s_cfg_tlast) begin
          sealed    <= 1'b1;
          n_entries <= wr_ptr + PTR_W'(1);
          wr_ptr    <= '0;
        end else begin
          sealed <= 1'b0;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end

      if (start_ok) begin
        idx    <= '0;
        busy_q <= 1'b1;
      end

      if (load_entry) begin
        sw0_q   <= cur_ent[CNT_W +: SW_W];
        sw1_q   <= cur_ent[CNT_W+SW_W +: SW_W];
        beats_q <= cur_ent[CNT_W-1:0];
        cnt0    <= '0;
        cnt1    <= '0;
      end

      if (state_q == RUN) begin
        cnt0 <= cnt0_nx;
        cnt1 <= cnt1_nx;
      end

      if (advance) idx <= idx + IDX_W'(1);

      if (state_q == FINISH) begin
        busy_q <= 1'b0;
        sw0_q  <= '0;
        sw1_q  <= '0;
      end
    end
  end

  assign s_droute_switch_0 = sw0_q;
  assign s_droute_switch_1 = sw1_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign cur_idx           = idx;

endmodule
